vdu_mem_arbiter: RTL

//  Two-port arbiter/sequencer for the VDU video-memory bus (a, d, memr, memw).

---
 rtl/vdu_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vdu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vdu_mem_arbiter
//   Shares the VDU video-memory bus (a, d, memr, memw) between two request
//   ports: port 0 (CPU bridge) and port 1 (test/pattern writer). Each granted
//   request becomes exactly one write or read cycle with fixed strobe timing.
//   Requests addressing outside the text window [WIN_BASE, WIN_LAST] finish
//   with err=1 and never touch the bus.
//
// Ports
//   clk, rst                     clock (posedge), synchronous active-low reset
//   req*/we*/addr*/wdata*        per-port request: level req, 1=write/0=read
//   ack0/ack1                    1-cycle pulse when the port's request is latched
//   done0/done1                  1-cycle pulse when the port's cycle finishes
//   err                          with done*: address was outside the window
//   rdata                        read data, valid with done* of a read, held
//   a, d, memr, memw             video memory bus; d driven only while writing
//   busy                         high in every state except IDLE
// ---------------------------------------------------------------------------
module vdu_mem_arbiter #(
    parameter logic [19:0] WIN_BASE = 20'hB8000,
    parameter logic [19:0] WIN_LAST = 20'hBBFFF,
    parameter int unsigned RD_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [19:0] addr0,
    input  logic [7:0]  wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [19:0] addr1,
    input  logic [7:0]  wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [19:0] a,
    inout  wire  [7:0]  d,
    output logic        memr,
    output logic        memw,
    output logic        busy
);

    // GRANT is the ack cycle: the request is latched and the window check is
    // resolved from the latched address before any strobe is raised.
    typedef enum logic [2:0] {
        IDLE, GRANT, W_ACT, W_REL, R_ACT, ERR, DONE
    } state_t;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [19:0] addr;
        logic [7:0]  wdata;
    } req_t;

    state_t      state;
    req_t        cur;
    logic        ptr;       // port preferred when both request together
    logic [2:0]  rd_cnt;    // remaining extra memr cycles
    logic [7:0]  d_out;
    logic        d_oe;

    logic        gnt_any;
    logic        gnt_port;
    logic        legal;

    assign d    = d_oe ? d_out : 8'hzz;
    assign busy = (state != IDLE);

    always_comb begin
        gnt_any  = req0 | req1;
        gnt_port = (req0 && req1) ? ptr : req1;
        legal    = (cur.addr >= WIN_BASE) && (cur.addr <= WIN_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cur    <= '0;
            ptr    <= 1'b0;
            rd_cnt <= '0;
            d_out  <= '0;
            d_oe   <= 1'b0;
            a      <= WIN_BASE;
            memr   <= 1'b0;
            memw   <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        cur  <= gnt_port ? req_t'{1'b1, we1, addr1, wdata1}
                                         : req_t'{1'b0, we0, addr0, wdata0};
                        ack0 <= !gnt_port;
                        ack1 <= gnt_port;
                        // round-robin only moves on contention
                        if (req0 && req1)
                            ptr <= !gnt_port;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!legal) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else if (cur.we) begin
                        a     <= cur.addr;
                        d_out <= cur.wdata;
                        d_oe  <= 1'b1;
                        memw  <= 1'b1;
                        state <= W_ACT;
                    end else begin
                        a      <= cur.addr;
                        memr   <= 1'b1;
                        rd_cnt <= 3'(RD_WAIT);
                        state  <= R_ACT;
                    end
                end
                W_ACT: begin
                    memw  <= 1'b0;
                    d_oe  <= 1'b0;
                    state <= W_REL;
                end
                W_REL: begin
                    done0 <= !cur.port;
                    done1 <= cur.port;
                    state <= DONE;
                end
                R_ACT: begin
                    if (rd_cnt == 3'd0) begin
                        // last memr cycle: data is sampled on this edge
                        rdata <= d;
                        memr  <= 1'b0;
                        done0 <= !cur.port;
                        done1 <= cur.port;
                        state <= DONE;
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end
                ERR: begin
                    done0 <= !cur.port;
                    done1 <= cur.port;
                    state <= DONE;
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
